// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder datapath and sequencer for two external
// WIDTH-bit right shift registers (augend A, addend B). Operands are consumed
// LSB first; the sum bit is fed back into A and B recirculates into itself,
// so after WIDTH shifts A holds A+B, B is unchanged and carry_out holds the
// final carry.
module serial_add_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic a_bit,
  input  logic b_bit,
  output logic shift_ctrl,
  output logic sum_bit,
  output logic b_recirc,
  output logic carry_out,
  output logic busy,
  output logic done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   count;
  logic            carry;
  logic            carry_next;
  logic            shift_q;
  logic            done_q;

  // Full-adder carry from the current serial operand bits and the stored carry
  assign carry_next = (a_bit & b_bit) | (a_bit & carry) | (b_bit & carry);

  assign sum_bit    = a_bit ^ b_bit ^ carry;
  assign b_recirc   = b_bit;
  assign carry_out  = carry;
  assign shift_ctrl = shift_q;
  assign busy       = shift_q;
  assign done       = done_q;

  // Sequencer: counts WIDTH shift cycles, updates the carry, registers the Moore outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      count   <= '0;
      carry   <= 1'b0;
      shift_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            state   <= SHIFT;
            count   <= '0;
            carry   <= 1'b0;
            shift_q <= 1'b1;
          end
        end
        SHIFT: begin
          carry <= carry_next;
          if (count == LAST) begin
            // Hold the counter on the last shift so it never wraps
            state   <= DONE;
            shift_q <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            count <= count + CW'(1);
          end
        end
        DONE: begin
          state  <= IDLE;
          done_q <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          shift_q <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: drives a WIDTH=4 and a WIDTH=8 instance of
// serial_add_ctrl, each wrapped in bench-side A/B shift registers, and
// compares every cycle against an arithmetic model of the add timeline.
module tb_serial_add_ctrl;

  localparam int W0 = 4;
  localparam int W1 = 8;

  logic        clk;
  logic        rst;
  logic        start_s  [2];
  logic        shift_s  [2];
  logic        sum_s    [2];
  logic        recirc_s [2];
  logic        carry_s  [2];
  logic        busy_s   [2];
  logic        done_s   [2];

  logic [63:0] reg_a [2];
  logic [63:0] reg_b [2];
  logic        ld_en [2];
  logic [63:0] ld_a  [2];
  logic [63:0] ld_b  [2];

  // Model of the add timeline: edge index of the accepted start and its operands
  longint      edge_n;
  longint      op_edge  [2];
  logic        op_valid [2];
  logic [63:0] a0 [2];
  logic [63:0] b0 [2];

  int vectors;
  int miscompares;

  serial_add_ctrl #(.WIDTH(W0)) u_add4 (
    .clk(clk), .rst(rst), .start(start_s[0]),
    .a_bit(reg_a[0][0]), .b_bit(reg_b[0][0]),
    .shift_ctrl(shift_s[0]), .sum_bit(sum_s[0]), .b_recirc(recirc_s[0]),
    .carry_out(carry_s[0]), .busy(busy_s[0]), .done(done_s[0])
  );

  serial_add_ctrl #(.WIDTH(W1)) u_add8 (
    .clk(clk), .rst(rst), .start(start_s[1]),
    .a_bit(reg_a[1][0]), .b_bit(reg_b[1][0]),
    .shift_ctrl(shift_s[1]), .sum_bit(sum_s[1]), .b_recirc(recirc_s[1]),
    .carry_out(carry_s[1]), .busy(busy_s[1]), .done(done_s[1])
  );

  function automatic int wid(int i);
    return (i == 0) ? W0 : W1;
  endfunction

  function automatic logic [63:0] lowmask(int n);
    if (n >= 64) return '1;
    return (64'd1 << n) - 64'd1;
  endfunction

  // Expected carry: carry out of the low d bits of A0+B0, or bit WIDTH once finished
  function automatic logic exp_carry(int i);
    logic [64:0] s;
    longint d;
    if (!op_valid[i]) return 1'b0;
    d = edge_n - op_edge[i];
    if (d >= longint'(wid(i))) begin
      s = {1'b0, a0[i]} + {1'b0, b0[i]};
      return s[wid(i)];
    end
    s = {1'b0, a0[i] & lowmask(int'(d))} + {1'b0, b0[i] & lowmask(int'(d))};
    return s[int'(d)];
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External A/B shift registers sharing clk and rst with the DUTs
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        reg_a[i] <= '0;
        reg_b[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (ld_en[i]) begin
          reg_a[i] <= ld_a[i] & lowmask(wid(i));
          reg_b[i] <= ld_b[i] & lowmask(wid(i));
        end else if (shift_s[i]) begin
          reg_a[i] <= (reg_a[i] >> 1) | (64'(sum_s[i]) << (wid(i) - 1));
          reg_b[i] <= (reg_b[i] >> 1) | (64'(recirc_s[i]) << (wid(i) - 1));
        end
      end
    end
  end

  // Model update: a start is accepted when the previous add is at least WIDTH+1 edges old
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) op_valid[i] <= 1'b0;
    end else begin
      edge_n <= edge_n + 1;
      for (int i = 0; i < 2; i++) begin
        if (start_s[i] && (!op_valid[i] ||
            (edge_n - op_edge[i] >= longint'(wid(i) + 1)))) begin
          op_valid[i] <= 1'b1;
          op_edge[i]  <= edge_n + 1;
          a0[i]       <= reg_a[i];
          b0[i]       <= reg_b[i];
        end
      end
    end
  end

  task automatic checkOutput(string name, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every instance against the model
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic   eb, ed;
      logic [64:0] s;
      longint d;
      d  = edge_n - op_edge[i];
      eb = rst && op_valid[i] && (d < longint'(wid(i)));
      ed = rst && op_valid[i] && (d == longint'(wid(i)));
      checkOutput($sformatf("shift_ctrl[%0d]", i), 64'(shift_s[i]), 64'(eb));
      checkOutput($sformatf("busy[%0d]", i), 64'(busy_s[i]), 64'(eb));
      checkOutput($sformatf("done[%0d]", i), 64'(done_s[i]), 64'(ed));
      checkOutput($sformatf("carry_out[%0d]", i), 64'(carry_s[i]),
                  64'(rst ? exp_carry(i) : 1'b0));
      if (eb) begin
        s = {1'b0, a0[i]} + {1'b0, b0[i]};
        checkOutput($sformatf("sum_bit[%0d]", i), 64'(sum_s[i]), 64'(s[int'(d)]));
        checkOutput($sformatf("b_recirc[%0d]", i), 64'(recirc_s[i]), 64'(b0[i][int'(d)]));
      end
    end
  end

  task automatic loadOperands(int i, logic [63:0] a, logic [63:0] b);
    @(negedge clk); #1;
    ld_a[i] = a; ld_b[i] = b; ld_en[i] = 1'b1;
    @(negedge clk); #1;
    ld_en[i] = 1'b0;
  endtask

  // Load operands, pulse start, optionally re-pulse start in SHIFT cycle 2 and in DONE
  task automatic applyStimulus(int i, logic [63:0] a, logic [63:0] b, bit noisy,
                               output int shifts, output int dones);
    loadOperands(i, a, b);
    shifts = 0;
    dones  = 0;
    for (int j = 0; j < wid(i) + 4; j++) begin
      start_s[i] = (j == 0) || (noisy && (j == 2 || j == wid(i) + 1));
      @(negedge clk);
      if (shift_s[i]) shifts++;
      if (done_s[i])  dones++;
      #1;
    end
    start_s[i] = 1'b0;
  endtask

  task automatic checkResult(int i, logic [63:0] a, logic [63:0] b, int shifts, int dones);
    logic [64:0] s;
    s = {1'b0, a & lowmask(wid(i))} + {1'b0, b & lowmask(wid(i))};
    checkOutput($sformatf("shift_count[%0d]", i), 64'(shifts), 64'(wid(i)));
    checkOutput($sformatf("done_count[%0d]", i), 64'(dones), 64'd1);
    checkOutput($sformatf("a_final[%0d]", i), reg_a[i], s[63:0] & lowmask(wid(i)));
    checkOutput($sformatf("b_final[%0d]", i), reg_b[i], b & lowmask(wid(i)));
    checkOutput($sformatf("carry_final[%0d]", i), 64'(carry_s[i]), 64'(s[wid(i)]));
  endtask

  initial begin
    int sh, dn;
    vectors = 0;
    miscompares = 0;
    edge_n = 0;
    for (int i = 0; i < 2; i++) begin
      start_s[i] = 1'b0; ld_en[i] = 1'b0; ld_a[i] = '0; ld_b[i] = '0;
      op_edge[i] = 0; a0[i] = '0; b0[i] = '0;
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      checkOutput("reset_shift", 64'(shift_s[i]), 64'd0);
      checkOutput("reset_done", 64'(done_s[i]), 64'd0);
      checkOutput("reset_carry", 64'(carry_s[i]), 64'd0);
    end
    rst = 1'b1;

    $display("[TB] basic add 0101+0011");
    applyStimulus(0, 64'h5, 64'h3, 1'b0, sh, dn);
    checkResult(0, 64'h5, 64'h3, sh, dn);
    checkOutput("basic_a_literal", reg_a[0], 64'h8);
    checkOutput("basic_carry_literal", 64'(carry_s[0]), 64'd0);

    $display("[TB] overflow 1111+0001");
    applyStimulus(0, 64'hF, 64'h1, 1'b0, sh, dn);
    checkResult(0, 64'hF, 64'h1, sh, dn);
    checkOutput("ovf_a_literal", reg_a[0], 64'h0);
    repeat (3) @(negedge clk);
    #1;
    checkOutput("ovf_carry_hold_literal", 64'(carry_s[0]), 64'd1);

    $display("[TB] stale carry 0010+0001");
    applyStimulus(0, 64'h2, 64'h1, 1'b0, sh, dn);
    checkResult(0, 64'h2, 64'h1, sh, dn);
    checkOutput("stale_a_literal", reg_a[0], 64'h3);
    checkOutput("stale_carry_literal", 64'(carry_s[0]), 64'd0);

    $display("[TB] start while busy 0110+0111");
    applyStimulus(0, 64'h6, 64'h7, 1'b1, sh, dn);
    checkResult(0, 64'h6, 64'h7, sh, dn);
    checkOutput("busy_a_literal", reg_a[0], 64'hD);

    $display("[TB] reset mid-op");
    loadOperands(0, 64'h5, 64'h3);
    start_s[0] = 1'b1;
    @(posedge clk);
    #1;
    start_s[0] = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    checkOutput("midop_busy_before", 64'(busy_s[0]), 64'd1);
    rst = 1'b0;
    #1;
    checkOutput("midop_shift_async", 64'(shift_s[0]), 64'd0);
    checkOutput("midop_busy_async", 64'(busy_s[0]), 64'd0);
    checkOutput("midop_done_async", 64'(done_s[0]), 64'd0);
    checkOutput("midop_carry_async", 64'(carry_s[0]), 64'd0);
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b1;
    applyStimulus(0, 64'h1, 64'h1, 1'b0, sh, dn);
    checkResult(0, 64'h1, 64'h1, sh, dn);
    checkOutput("midop_after_literal", reg_a[0], 64'h2);

    $display("[TB] WIDTH=8 FF+01");
    applyStimulus(1, 64'hFF, 64'h01, 1'b0, sh, dn);
    checkResult(1, 64'hFF, 64'h01, sh, dn);
    checkOutput("w8_a_literal", reg_a[1], 64'h00);
    checkOutput("w8_carry_literal", 64'(carry_s[1]), 64'd1);
    checkOutput("w8_shift_literal", 64'(sh), 64'd8);

    $display("[TB] randomized adds");
    for (int n = 0; n < 40; n++) begin
      int          i;
      logic [63:0] ra, rb;
      i  = int'($urandom_range(1, 0));
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      applyStimulus(i, ra, rb, bit'($urandom_range(1, 0)), sh, dn);
      checkResult(i, ra, rb, sh, dn);
    end

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
